a0_trace_buffer: RTL and testbench
==================================

# a0_trace_buffer

Change-capture trace buffer that sits directly downstream of the pipelined RISC-V core and consumes its `a0` output. Each cycle it compares the core's `a0` with the last captured value. On a change it pushes the new value, with a cycle timestamp, into an internal FIFO. A valid/ready stream drains the FIFO toward a display driver or testbench monitor, so no `a0` update is lost when the consumer is slower than the core.

## Interface
- `DATA_WIDTH`, 32: width of `a0` and `out_data`.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `STAMP_WIDTH`, 16: timestamp counter width.
- `clk` input 1: sole clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-low.
- `en` input 1: capture enable (normally tied to the core's `trigger`).
- `a0` input DATA_WIDTH: core register x10 value.
- `out_valid` output 1: head entry available.
- `out_ready` input 1: consumer accepts the head entry.
- `out_data` output DATA_WIDTH: captured `a0` value at the head.
- `out_stamp` output STAMP_WIDTH: timestamp of the head entry.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: sticky flag, set when a capture was dropped.
- `clr_overflow` input 1: clears `overflow`.

## Operation
- Internal state: `last` (DATA_WIDTH), `last_valid`, free-running `stamp_ctr`, and the FIFO (storage, read pointer, write pointer, count).
- Capture condition, evaluated every cycle: `cap = en && (!last_valid || a0 != last)`.
- On `cap`, `last` ← `a0` and `last_valid` ← 1. This update happens even if the push is dropped, so a dropped value is never retried.
- `en` low freezes `last`/`last_valid`. When capture resumes, only values that differ from `last` are pushed.
- Push attempt on `cap` with entry {`a0`, current `stamp_ctr`}:
  - Accepted if `count < DEPTH`, or if `count == DEPTH` and a pop happens in the same cycle.
  - Otherwise the entry is dropped and `overflow` is set.
- Pop occurs when `out_valid && out_ready`. `out_ready` while empty has no effect.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. This applies at empty, partial and full occupancy.
- Pointers wrap modulo DEPTH. `count` disambiguates full from empty.
- `stamp_ctr` increments every cycle after reset and wraps from 2^STAMP_WIDTH−1 to 0. No flag is raised on wrap.
- `overflow`: set has priority over `clr_overflow` in the same cycle. Once set, it stays set until `clr_overflow` in a cycle with no drop.
- `out_data`/`out_stamp` are forced to 0 whenever `out_valid` is 0.

## Timing
- Reset (`rst` = 0 at a clock edge) drives the following; FIFO contents are discarded:
  - `count` = 0, `out_valid` = 0, `out_data` = 0, `out_stamp` = 0, `overflow` = 0.
  - `last_valid` = 0, `last` = 0, `stamp_ctr` = 0.
- Reset asserted mid-stream discards all entries at that edge. Any in-flight pop handshake in that cycle is void.
- The first cycle after reset release with `en` = 1 always captures, since `last_valid` = 0. Its stamp is 0.
- Push latency: an entry captured at edge N is visible on `out_valid`/`out_data` after edge N. There is no combinational bypass from `a0` to `out_data`.
- `out_valid`, `count` and `overflow` are registered. `out_data`/`out_stamp` are a read of the registered head entry, masked by registered `out_valid`.
- Throughput: one push and one pop per cycle sustained.
- The consumer must not rely on `out_data` being held after a pop; a new head appears the following cycle.

## Configuration
- Macro `A0_TRACE_STAMP_EN`.
- Defined: timestamp counter and per-entry stamp storage are built; `out_stamp` behaves as above.
- Undefined: counter and stamp storage are omitted. `out_stamp` is tied to 0 and the port list is unchanged. All other behaviour is identical.

## Test plan
- Reset, then `en` = 1 with `a0` held at 0x0: exactly one entry {0x0, stamp 0}; `count` = 1; no further pushes over 20 cycles.
- `a0` sequence 5, 5, 7, 7, 9 with `out_ready` = 0: `count` = 3 (after the initial capture of 5); pop order 5, 7, 9; stamps strictly increasing.
- Fill to DEPTH = 16 with `out_ready` = 0, then change `a0` once:
  - `overflow` = 1 and `count` stays 16.
  - Changing `a0` back to the dropped value does not push it.
  - `clr_overflow` clears the flag.
- At full, change `a0` and assert `out_ready` in the same cycle: the push is accepted, `count` stays 16 and `overflow` stays 0.
- Toggle `a0` every cycle while randomly toggling `out_ready` and `en` for 1000 cycles: the scoreboard matches every accepted change; `out_data`/`out_stamp` are 0 whenever `out_valid` = 0. Separately, drive `rst` = 0 while `count` = 8: after the edge, `count` = 0 and `overflow` = 0.
- With the macro defined and STAMP_WIDTH = 4: a change at cycle 17 is stamped 1 (wrap). With the macro undefined: `out_stamp` is always 0.

Source files
------------

// File: rtl/a0_trace_buffer_if.sv
// Stream/control bundle between the a0 change-capture trace buffer (slave) and
// the core/consumer side (master).
interface a0_trace_buffer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int STAMP_WIDTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   en;
  logic [DATA_WIDTH-1:0]  a0;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [STAMP_WIDTH-1:0] out_stamp;
  logic [CW-1:0]          count;
  logic                   overflow;
  logic                   clr_overflow;

  modport master (
    output en, a0, out_ready, clr_overflow,
    input  out_valid, out_data, out_stamp, count, overflow
  );

  modport slave (
    input  en, a0, out_ready, clr_overflow,
    output out_valid, out_data, out_stamp, count, overflow
  );
endinterface

// File: rtl/a0_trace_buffer.sv
// Captures every change of the core's a0 into a FIFO drained by a valid/ready stream.
// Define A0_TRACE_STAMP_EN to build the cycle timestamp counter and per-entry stamps.
module a0_trace_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int STAMP_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  a0_trace_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic [DATA_WIDTH-1:0] r_last;
  logic                  r_last_valid;

  logic w_out_valid;
  logic w_cap;
  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;

  assign w_out_valid = (r_count != '0);
  assign w_cap       = bus.en && (!r_last_valid || (bus.a0 != r_last));
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_full      = (r_count == CW'(DEPTH));
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push      = w_cap && (!w_full || w_pop);
  assign w_drop      = w_cap && !w_push;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_last       <= '0;
      r_last_valid <= 1'b0;
    end else begin
      // last tracks the captured value even when its push is dropped
      if (w_cap) begin
        r_last       <= bus.a0;
        r_last_valid <= 1'b1;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)                r_overflow <= 1'b1;
      else if (bus.clr_overflow) r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) r_mem[r_wr_ptr] <= bus.a0;
  end

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;

`ifdef A0_TRACE_STAMP_EN
  logic [STAMP_WIDTH-1:0] r_stamp_ctr;
  logic [STAMP_WIDTH-1:0] r_stamp_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) r_stamp_ctr <= '0;
    else      r_stamp_ctr <= r_stamp_ctr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst && w_push) r_stamp_mem[r_wr_ptr] <= r_stamp_ctr;
  end

  assign bus.out_stamp = w_out_valid ? r_stamp_mem[r_rd_ptr] : '0;
`else
  assign bus.out_stamp = {STAMP_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_a0_trace_buffer.sv
// Directed and scoreboarded checks for a0_trace_buffer (stamp checks follow A0_TRACE_STAMP_EN).
module tb_a0_trace_buffer;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int SW    = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DW-1:0] d;
    int            s;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  a0_trace_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STAMP_WIDTH(SW)) bus();

  a0_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STAMP_WIDTH(SW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // cycles since reset release; equals the stamp a capture at the next edge gets
  always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_st(input int c);
    logic [63:0] v;
    v = 64'(c[SW-1:0]);
`ifndef A0_TRACE_STAMP_EN
    v = '0;
`endif
    return v;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   st[3];
    int   seq[5];
    int   exp_d[3];
    int   k;
    logic [DW-1:0] prev;
    ent_t q[$];
    logic [DW-1:0] m_last;
    logic          m_lv;
    logic          m_ovf;
    int            m_st;
    logic          pop, cap, push;

    bus.en = 1'b0; bus.a0 = '0; bus.out_ready = 1'b0; bus.clr_overflow = 1'b0;
    rst = 1'b0;
    step(2);
    check("rst_count", 64'(bus.count), 0);
    check("rst_valid", 64'(bus.out_valid), 0);
    check("rst_data", 64'(bus.out_data), 0);
    check("rst_stamp", 64'(bus.out_stamp), 0);
    check("rst_ovf", 64'(bus.overflow), 0);

    // first enabled cycle after reset always captures, stamp 0
    rst = 1'b1; bus.en = 1'b1; bus.a0 = 32'h0;
    step();
    check("first_count", 64'(bus.count), 1);
    check("first_valid", 64'(bus.out_valid), 1);
    check("first_data", 64'(bus.out_data), 0);
    check("first_stamp", 64'(bus.out_stamp), exp_st(0));
    step(20);
    check("hold_count", 64'(bus.count), 1);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    check("pop1_count", 64'(bus.count), 0);
    check("empty_data", 64'(bus.out_data), 0);

    // 5,5,7,7,9 -> three entries
    seq = '{5, 5, 7, 7, 9};
    exp_d = '{5, 7, 9};
    prev = '0; k = 0;
    for (int i = 0; i < 5; i++) begin
      if (32'(seq[i]) != prev) begin st[k] = cyc; k++; end
      prev = 32'(seq[i]);
      bus.a0 = 32'(seq[i]);
      step();
    end
    check("seq_count", 64'(bus.count), 3);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("seq_data", 64'(bus.out_data), 64'(exp_d[i]));
      check("seq_stamp", 64'(bus.out_stamp), exp_st(st[i]));
      step();
    end
    bus.out_ready = 1'b0;
    check("seq_empty", 64'(bus.count), 0);

    // fill, then overflow
    for (int i = 0; i < 16; i++) begin bus.a0 = 32'(100 + i); step(); end
    check("fill_count", 64'(bus.count), 16);
    check("fill_ovf", 64'(bus.overflow), 0);
    bus.a0 = 32'd200; step();
    check("drop_ovf", 64'(bus.overflow), 1);
    check("drop_count", 64'(bus.count), 16);
    step(2);
    check("drop_hold", 64'(bus.count), 16);
    bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    check("no_retry", 64'(bus.count), 15);
    check("head_101", 64'(bus.out_data), 101);
    bus.clr_overflow = 1'b1; step(); bus.clr_overflow = 1'b0;
    check("clr_ovf", 64'(bus.overflow), 0);
    bus.a0 = 32'd300; step();
    check("refill_count", 64'(bus.count), 16);
    bus.a0 = 32'd301; bus.out_ready = 1'b1; step(); bus.out_ready = 1'b0;
    check("full_pp_count", 64'(bus.count), 16);
    check("full_pp_ovf", 64'(bus.overflow), 0);
    check("full_pp_head", 64'(bus.out_data), 102);
    bus.a0 = 32'd302; bus.clr_overflow = 1'b1; step(); bus.clr_overflow = 1'b0;
    check("set_prio", 64'(bus.overflow), 1);
    check("set_prio_count", 64'(bus.count), 16);

    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_data", 64'(bus.out_data), (i < 14) ? 64'(102 + i) : ((i == 14) ? 64'd300 : 64'd301));
      step();
    end
    bus.out_ready = 1'b0;
    check("drain_count", 64'(bus.count), 0);
    check("drain_valid", 64'(bus.out_valid), 0);
    check("drain_data0", 64'(bus.out_data), 0);
    check("drain_ovf_sticky", 64'(bus.overflow), 1);

    // reset mid-stream at count 8
    for (int i = 0; i < 8; i++) begin bus.a0 = 32'(400 + i); step(); end
    check("mid_count8", 64'(bus.count), 8);
    bus.out_ready = 1'b1; rst = 1'b0; step();
    bus.out_ready = 1'b0;
    check("mid_rst_count", 64'(bus.count), 0);
    check("mid_rst_ovf", 64'(bus.overflow), 0);
    check("mid_rst_valid", 64'(bus.out_valid), 0);

    // scoreboard run
    m_last = '0; m_lv = 1'b0; m_ovf = 1'b0; m_st = 0;
    rst = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus.a0           = 32'($urandom_range(0, 3));
      bus.en           = ($urandom_range(0, 3) != 0);
      bus.out_ready    = ($urandom_range(0, 1) != 0);
      bus.clr_overflow = ($urandom_range(0, 7) == 0);
      pop  = (q.size() > 0) && bus.out_ready;
      cap  = bus.en && (!m_lv || bus.a0 != m_last);
      push = cap && ((q.size() < DEPTH) || pop);
      if (cap) begin m_last = bus.a0; m_lv = 1'b1; end
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{d: bus.a0, s: m_st});
      if (cap && !push) m_ovf = 1'b1;
      else if (bus.clr_overflow) m_ovf = 1'b0;
      m_st++;
      step();
      check("rnd_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      check("rnd_count", 64'(bus.count), 64'(q.size()));
      check("rnd_ovf", 64'(bus.overflow), 64'(m_ovf));
      check("rnd_data", 64'(bus.out_data), (q.size() > 0) ? 64'(q[0].d) : 64'd0);
      check("rnd_stamp", 64'(bus.out_stamp), (q.size() > 0) ? exp_st(q[0].s) : 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
